// File: rtl/uart_tx_param.sv
// Parametrised serial transmitter: start bit, DATA_BITS data bits sent LSB
// first, optional odd/even parity, then 1 or 2 stop bits.
// The baud counter restarts on every accept, so bit edges line up with the
// accept edge instead of a free-running tick.
module uart_tx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 ctrl,
  output logic                 ready,
  output logic                 tx_data,
  output logic                 done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BIT_END  = BW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DIV - 2);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  // Elaboration-time parameter checks; an illegal value stops the build.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [BW-1:0]        bcnt;
  logic [3:0]           bitcnt;
  logic                 stopcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;

  // Last clock of the current bit period.
  assign bit_end = (bcnt == BIT_END);

  // Frame sequencer; tx_data, ready and done are all registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx_data <= 1'b1;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) bcnt <= bit_end ? '0 : bcnt + 1'b1;
      case (state)
        IDLE: begin
          if (ctrl) begin
            shreg   <= data;
            par_bit <= (PARITY == 1) ? ~^data : ^data;
            bcnt    <= '0;
            tx_data <= 1'b0;
            ready   <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bitcnt  <= '0;
            tx_data <= shreg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) begin
              if (PARITY != 0) begin
                tx_data <= par_bit;
                state   <= PAR;
              end else begin
                stopcnt <= 1'b0;
                tx_data <= 1'b1;
                state   <= STOP;
              end
            end else begin
              // Next bit is already sitting one place up in the register.
              tx_data <= shreg[1];
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            stopcnt <= 1'b0;
            tx_data <= 1'b1;
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stopcnt == LAST_STOP) begin
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              stopcnt <= stopcnt + 1'b1;
            end
          end else if (bcnt == BIT_LAST && stopcnt == LAST_STOP) begin
            // Registered, so set one clock early to land on the final clock.
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations side by side (8N1, 8E1, 8O1,
// 5N2) at DIV=16. A cycle-level line model checks tx/ready/done every clock
// from a scoreboard of expected frames; table rows and a few sequences drive it.
module tb_uart_tx_param;

  localparam int DIV = 16;

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       par;
    int         len;
  } vec_t;

  typedef struct {
    logic [15:0] bits;
    int          nb;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ctl = '0;
  logic [7:0] din [4];
  logic       rdy [4];
  logic       txl [4];
  logic       dn  [4];

  int     nbits  [4] = '{8, 8, 8, 5};
  int     haspar [4] = '{0, 1, 1, 0};
  int     cur_len[4];
  logic   cur_par[4];
  logic   idle_seen[4];
  frame_t sbq[4][$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data(din[0]), .ctrl(ctl[0]), .ready(rdy[0]), .tx_data(txl[0]), .done(dn[0]));
  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .data(din[1]), .ctrl(ctl[1]), .ready(rdy[1]), .tx_data(txl[1]), .done(dn[1]));
  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .data(din[2]), .ctrl(ctl[2]), .ready(rdy[2]), .tx_data(txl[2]), .done(dn[2]));
  uart_tx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .data(din[3][4:0]), .ctrl(ctl[3]), .ready(rdy[3]), .tx_data(txl[3]), .done(dn[3]));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Posedge: accept model pushes the expected frame. Negedge: pop and compare.
  task automatic monitor();
    frame_t     cur [4];
    int         pos [4];
    logic       active [4];
    logic [2:0] exp;
    frame_t     fr;
    for (int d = 0; d < 4; d++) begin
      active[d] = 1'b0; pos[d] = 0; idle_seen[d] = 1'b1;
    end
    forever begin
      @(clk);
      if (clk) begin
        if (rst) begin
          for (int d = 0; d < 4; d++) begin
            if (idle_seen[d] && ctl[d]) begin
              fr.nb   = cur_len[d] / DIV;
              fr.bits = '1;
              fr.bits[0] = 1'b0;
              for (int i = 0; i < nbits[d]; i++) fr.bits[1+i] = din[d][i];
              if (haspar[d] != 0) fr.bits[1+nbits[d]] = cur_par[d];
              sbq[d].push_back(fr);
              idle_seen[d] = 1'b0;
            end
          end
        end
      end else begin
        for (int d = 0; d < 4; d++) begin
          if (!rst) begin
            sbq[d].delete();
            active[d] = 1'b0;
            idle_seen[d] = 1'b1;
            exp = 3'b110;
          end else begin
            if (!active[d] && sbq[d].size() > 0) begin
              cur[d] = sbq[d].pop_front();
              active[d] = 1'b1;
              pos[d] = 0;
            end
            if (active[d]) begin
              exp = {cur[d].bits[pos[d]/DIV], 1'b0, (pos[d] == cur[d].nb*DIV - 1)};
              pos[d]++;
              if (pos[d] == cur[d].nb*DIV) active[d] = 1'b0;
              idle_seen[d] = 1'b0;
            end else begin
              exp = 3'b110;
              idle_seen[d] = 1'b1;
            end
          end
          check($sformatf("line[%0d] {tx,ready,done}", d), {29'd0, txl[d], rdy[d], dn[d]}, {29'd0, exp});
        end
      end
    end
  endtask

  // One-cycle request pulse; returns at the first negedge after the accept edge.
  task automatic send(int d, logic [7:0] data, logic par, int len);
    @(negedge clk);
    cur_len[d] = len;
    cur_par[d] = par;
    din[d]     = data;
    ctl[d]     = 1'b1;
    @(negedge clk);
    ctl[d]     = 1'b0;
  endtask

  // Count ready-low clocks and locate the done pulse, bounded by a budget.
  task automatic wait_frame(int d, int len);
    int lo = 0;
    int dn_at = -1;
    for (int k = 0; k < len + 32; k++) begin
      if (rdy[d]) break;
      lo++;
      if (dn[d]) dn_at = k;
      @(negedge clk);
    end
    check($sformatf("ready_low_clks[%0d]", d), lo, len);
    check($sformatf("done_clk[%0d]", d), dn_at, len - 1);
  endtask

  localparam int NT = 10;
  vec_t tbl [NT];

  initial begin
    tbl[0] = '{0, 8'h55, 1'b0, 160};
    tbl[1] = '{1, 8'h07, 1'b1, 176};
    tbl[2] = '{2, 8'h07, 1'b0, 176};
    tbl[3] = '{3, 8'h13, 1'b0, 128};
    tbl[4] = '{0, 8'h00, 1'b0, 160};
    tbl[5] = '{0, 8'hFF, 1'b0, 160};
    tbl[6] = '{1, 8'hFF, 1'b0, 176};
    tbl[7] = '{2, 8'h80, 1'b0, 176};
    tbl[8] = '{2, 8'h00, 1'b1, 176};
    tbl[9] = '{3, 8'h1F, 1'b0, 128};
    for (int d = 0; d < 4; d++) begin
      din[d] = '0; cur_len[d] = 0; cur_par[d] = 1'b0;
    end

    #1 rst = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    for (int r = 0; r < NT; r++) begin
      send(tbl[r].d, tbl[r].data, tbl[r].par, tbl[r].len);
      wait_frame(tbl[r].d, tbl[r].len);
      repeat (3) @(negedge clk);
    end

    // Held request: two back-to-back frames, data changed mid-frame.
    @(negedge clk);
    cur_len[0] = 160; cur_par[0] = 1'b0;
    din[0] = 8'hA0;
    ctl[0] = 1'b1;
    repeat (80) @(negedge clk);
    din[0] = 8'h0F;
    repeat (120) @(negedge clk);
    ctl[0] = 1'b0;
    repeat (200) @(negedge clk);

    // Request while busy is dropped.
    send(0, 8'hC3, 1'b0, 160);
    repeat (40) @(negedge clk);
    ctl[0] = 1'b1;
    @(negedge clk);
    ctl[0] = 1'b0;
    repeat (200) @(negedge clk);

    // Reset in the middle of a frame, then a clean frame.
    send(0, 8'h3C, 1'b0, 160);
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst {tx,ready,done}", {29'd0, txl[0], rdy[0], dn[0]}, 32'd6);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'h55, 1'b0, 160);
    wait_frame(0, 160);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
